// File: rtl/store_buffer_if.sv
// Store-buffer bus bundle: writeback enqueue, D-cache drain and load probe.
// master = pipeline/memory side, slave = store buffer.
interface store_buffer_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  st_valid;
   logic [ADDR_WIDTH-1:0] st_addr;
   logic [DATA_WIDTH-1:0] st_data;
   logic                  st_ready;
   logic                  mem_valid;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  mem_ready;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic                  ld_hit;
   logic [DATA_WIDTH-1:0] ld_data;
   logic                  empty;

   modport master (
      output st_valid, st_addr, st_data, mem_ready, ld_addr,
      input  st_ready, mem_valid, mem_addr, mem_data, ld_hit, ld_data, empty
   );

   modport slave (
      input  st_valid, st_addr, st_data, mem_ready, ld_addr,
      output st_ready, mem_valid, mem_addr, mem_data, ld_hit, ld_data, empty
   );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer between writeback and D-cache; head visible 1 cycle after enqueue, no bypass.
// st_ready drops only on count==DEPTH (no ready->ready path); STORE_BUFFER_FWD_EN builds the youngest-match forward mux.
module store_buffer #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   store_buffer_if.slave bus
);
   localparam int             PW       = $clog2(DEPTH);
   localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
   logic [DATA_WIDTH-1:0] r_data [DEPTH];
   logic [DEPTH-1:0]      r_valid;
   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [PW:0]           r_count;

   logic                  w_enq;
   logic                  w_deq;
   logic [DEPTH-1:0]      w_match;

   assign bus.st_ready  = (r_count != FULL_CNT);
   assign bus.empty     = (r_count == '0);
   assign bus.mem_valid = r_valid[r_head];
   assign bus.mem_addr  = r_addr[r_head];
   assign bus.mem_data  = r_data[r_head];

   assign w_enq = bus.st_valid & bus.st_ready;
   assign w_deq = bus.mem_valid & bus.mem_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
      end else begin
         if (w_enq) begin
            r_addr[r_tail]  <= bus.st_addr;
            r_data[r_tail]  <= bus.st_data;
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + PW'(1);
         end
         if (w_deq) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PW'(1);
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Probe sees registered state only: same-cycle enqueue invisible, same-cycle drain still visible.
   always_comb begin
      w_match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_match[i] = r_valid[i] & (r_addr[i] == bus.ld_addr);
      end
   end

   assign bus.ld_hit = |w_match;

`ifdef STORE_BUFFER_FWD_EN
   logic [DATA_WIDTH-1:0] w_fwd_data;
   logic [PW-1:0]         w_idx;

   // Valid entries are contiguous from head, so the last match walking oldest->youngest wins.
   always_comb begin
      w_fwd_data = '0;
      w_idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_head + PW'(k);
         if (w_match[w_idx]) begin
            w_fwd_data = r_data[w_idx];
         end
      end
   end

   assign bus.ld_data = w_fwd_data;
`else
   assign bus.ld_data = '0;
`endif

endmodule
